// File: rtl/imm_gen_pfx.sv
// Registered, valid/ready-streamed immediate generator with PFX prefix accumulation for 16-bit MISC-V words.
// Optional IMMGEN_ZEXT_EN adds in_zext to select zero-extension per beat.
module imm_gen_pfx #(
    parameter int XLEN      = 16,
    parameter int PFX_DEPTH = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     instruction,
`ifdef IMMGEN_ZEXT_EN
    input  logic            in_zext,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic            imm_prefixed,
    output logic            imm_err
);

    localparam int ACC_W  = 10 * PFX_DEPTH;
    localparam int CAT_W  = ACC_W + 10;
    localparam int WIDE_W = (CAT_W > XLEN) ? CAT_W : XLEN;
    localparam int CNT_W  = $clog2(PFX_DEPTH + 1);
    localparam int TW_W   = $clog2(CAT_W + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PFX  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic             pfx_q, pfx_d;
    logic             err_q, err_d;

    logic [2:0]        opcode;
    logic              is_pfx;
    logic              accept;
    logic [9:0]        field;
    logic [3:0]        fw;
    logic [TW_W-1:0]   tw;
    logic [WIDE_W-1:0] cat;
    logic [WIDE_W-1:0] top_mask;
    logic              sign_bit;
    logic              sext_en;
    logic [XLEN-1:0]   ext_val;

    assign opcode   = instruction[2:0];
    assign is_pfx   = (opcode == 3'b000) && (instruction[5:3] == 3'b111);
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        field = '0;
        fw    = 4'd0;
        case (opcode)
            3'b001:         begin field = {5'b0, instruction[13:9]};                     fw = 4'd5;  end
            3'b010, 3'b011: begin field = {3'b0, instruction[15:9]};                     fw = 4'd7;  end
            3'b100, 3'b101: begin field = {3'b0, instruction[15:12], instruction[5:3]};  fw = 4'd7;  end
            3'b110, 3'b111: begin field = instruction[15:6];                             fw = 4'd10; end
            default:        begin field = '0;                                            fw = 4'd0;  end
        endcase
    end

    // acc holds only valid payload bits (upper bits stay zero), so {acc,field} is a plain shift-or
    // and the sign bit sits at position tw-1 of the concatenation.
    always_comb begin
        tw       = TW_W'(cnt_q) * TW_W'(10) + TW_W'(fw);
        cat      = (WIDE_W'(acc_q) << fw) | WIDE_W'(field);
        top_mask = {WIDE_W{1'b1}} << tw;
        sign_bit = |(cat & (top_mask >> 1) & ~top_mask);
`ifdef IMMGEN_ZEXT_EN
        sext_en  = sign_bit && !in_zext;
`else
        sext_en  = sign_bit;
`endif
        ext_val  = cat[XLEN-1:0] | (sext_en ? top_mask[XLEN-1:0] : '0);
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        imm_d       = imm_q;
        pfx_d       = pfx_q;
        err_d       = err_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
        end else if (accept) begin
            if (is_pfx) begin
                if (cnt_q < CNT_W'(PFX_DEPTH)) begin
                    acc_d   = (acc_q << 10) | ACC_W'(instruction[15:6]);
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_PFX;
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                out_valid_d = 1'b1;
                imm_d       = ext_val;
                pfx_d       = (state_q == ST_PFX);
                err_d       = ovf_q;
                state_d     = ST_IDLE;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            imm_q       <= '0;
            pfx_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            imm_q       <= imm_d;
            pfx_q       <= pfx_d;
            err_q       <= err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign imm          = imm_q;
    assign imm_prefixed = pfx_q;
    assign imm_err      = err_q;

endmodule
